if_prefetch_buffer: RTL and testbench

//  Instruction prefetch stage ahead of ID in the 16-bit pipeline. Issues fetch requests to

---
 rtl/if_prefetch_buffer.sv | 192 +++++++++++++++++++
 tb/tb_if_prefetch_buffer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// if_prefetch_buffer
//   Instruction prefetch stage sitting in front of ID in the 16-bit pipeline.
//   Fetches one word at a time from instruction memory (at most one request
//   outstanding), queues returned words together with their PC+2 tag in a
//   small FIFO and hands them to ID over a valid/ready handshake. A taken
//   branch/jump from MEM redirects fetch, flushes the queue and discards the
//   response that is still in flight.
//
// Ports
//   clock, reset_n         rising-edge clock, asynchronous active-low reset
//   redirect, redirect_addr  PCSrc from MEM and the new fetch target
//   imem_req, imem_addr    fetch request and its byte address
//   imem_ready             memory accepts the request this cycle
//   imem_rvalid, imem_rdata  read response
//   id_valid, id_ready     FIFO head handshake toward ID
//   id_instr, id_pc4       head instruction and head address + 2 (0 if empty)
//   count                  number of occupied FIFO entries
//
// Configuration
//   PREFETCH_PERF_CNT_EN   when defined, adds saturating counters
//                          perf_fetched (words queued) and perf_dropped
//                          (responses discarded by a redirect).
// ---------------------------------------------------------------------------
module if_prefetch_buffer #(
    parameter int unsigned        DATA_W   = 16,
    parameter int unsigned        ADDR_W   = 16,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_addr,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic                       imem_ready,
    input  logic                       imem_rvalid,
    input  logic [DATA_W-1:0]          imem_rdata,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [DATA_W-1:0]          id_instr,
    output logic [ADDR_W-1:0]          id_pc4,
    output logic [$clog2(DEPTH):0]     count
`ifdef PREFETCH_PERF_CNT_EN
    ,
    output logic [15:0]                perf_fetched,
    output logic [15:0]                perf_dropped
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = PTR_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] tag_pc4_q,  tag_pc4_d;
    logic              outstanding_q, outstanding_d;
    logic              discard_q,     discard_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic [DATA_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc4_mem_q   [DEPTH];

    logic accept;
    logic resp;
    logic push;
    logic pop;
    logic drop;

    // A request is only raised while a FIFO slot is free; since only one
    // request can be in flight, the eventual push can never overflow.
    always_comb begin
        imem_req = reset_n & ~outstanding_q & ~redirect & (count_q < DEPTH_C);
        accept   = imem_req & imem_ready;
        resp     = imem_rvalid & outstanding_q;
        push     = resp & ~discard_q & ~redirect;
        drop     = resp & (discard_q | redirect);
        pop      = (count_q != '0) & id_ready & ~redirect;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        tag_pc4_d     = tag_pc4_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        count_d       = count_q;

        if (redirect) begin
            fetch_pc_d = redirect_addr;
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            // A response arriving in the redirect cycle retires the request
            // here; otherwise the still-pending response must be thrown away.
            if (outstanding_q) begin
                if (imem_rvalid) begin
                    outstanding_d = 1'b0;
                    discard_d     = 1'b0;
                end else begin
                    discard_d     = 1'b1;
                end
            end
        end else begin
            if (accept) begin
                tag_pc4_d     = fetch_pc_q + ADDR_W'(2);
                fetch_pc_d    = fetch_pc_q + ADDR_W'(2);
                outstanding_d = 1'b1;
            end
            if (resp) begin
                outstanding_d = 1'b0;
                discard_d     = 1'b0;
            end
            if (push) wptr_d = wptr_q + PTR_W'(1);
            if (pop)  rptr_d = rptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= RESET_PC;
            tag_pc4_q     <= '0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc4_mem_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            tag_pc4_q     <= tag_pc4_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            if (push) begin
                instr_mem_q[wptr_q] <= imem_rdata;
                pc4_mem_q[wptr_q]   <= tag_pc4_q;
            end
        end
    end

    always_comb begin
        imem_addr = fetch_pc_q;
        count     = count_q;
        id_valid  = (count_q != '0);
        id_instr  = id_valid ? instr_mem_q[rptr_q] : '0;
        id_pc4    = id_valid ? pc4_mem_q[rptr_q]   : '0;
    end

`ifdef PREFETCH_PERF_CNT_EN
    logic [15:0] perf_fetched_q, perf_fetched_d;
    logic [15:0] perf_dropped_q, perf_dropped_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_dropped_d = perf_dropped_q;
        if (push && perf_fetched_q != '1) perf_fetched_d = perf_fetched_q + 16'd1;
        if (drop && perf_dropped_q != '1) perf_dropped_d = perf_dropped_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_dropped_q <= perf_dropped_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch_buffer
//   Directed bench for if_prefetch_buffer. A small instruction-memory model
//   answers each accepted request one cycle later (or holds it on request);
//   accepted fetch addresses and words consumed by ID are logged and compared
//   against hand-computed sequences.
// ---------------------------------------------------------------------------
module tb_if_prefetch_buffer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [15:0] id_instr;
    logic [15:0] id_pc4;
    logic [2:0]  count;
`ifdef PREFETCH_PERF_CNT_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_dropped;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] addr_log  [$];
    logic [15:0] instr_log [$];
    logic [15:0] pc4_log   [$];

    bit          hold_resp;
    bit          pending;
    logic [15:0] pend_addr;

    always #5 clock = ~clock;

    if_prefetch_buffer #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc4        (id_pc4),
        .count         (count)
`ifdef PREFETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_dropped  (perf_dropped)
`endif
    );

    // Memory contents: address 0 -> 0x1111, 2 -> 0x2222, 4 -> 0x3333, ...
    function automatic logic [15:0] word(input logic [15:0] a);
        logic [3:0] n;
        n = a[4:1] + 4'd1;
        return {n, n, n, n};
    endfunction

    // One clock cycle: sample handshakes, cross the edge, drive the response.
    task automatic step();
        bit          acc;
        logic [15:0] a;
        #1;
        acc = imem_req && imem_ready;
        a   = imem_addr;
        if (acc) begin
            addr_log.push_back(a);
            pending   = 1'b1;
            pend_addr = a;
        end
        if (id_valid && id_ready && !redirect) begin
            instr_log.push_back(id_instr);
            pc4_log.push_back(id_pc4);
        end
        @(posedge clock);
        #1;
        if (pending && !hold_resp) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word(pend_addr);
            pending     = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'h0000;
        end
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 16'h0000;
        imem_ready    = 1'b1;
        imem_rvalid   = 1'b0;
        imem_rdata    = 16'h0000;
        id_ready      = 1'b1;
        hold_resp     = 1'b0;
        pending       = 1'b0;
        addr_log.delete();
        instr_log.delete();
        pc4_log.delete();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        redirect    = 1'b0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        id_ready    = 1'b1;
        #3;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", id_valid); end
        checks++; if (id_instr !== 16'h0000) begin errors++; $display("FAIL rst_instr: got %h expected 0000", id_instr); end
        checks++; if (id_pc4 !== 16'h0000) begin errors++; $display("FAIL rst_pc4: got %h expected 0000", id_pc4); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
        do_reset();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_first_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_first_addr: got %h expected 0000", imem_addr); end
    endtask

    task automatic test_stream();
        int n;
        do_reset();
        n = 0;
        while (instr_log.size() < 3 && n < 40) begin step(); n++; end
        checks++;
        if (instr_log.size() < 3) begin
            errors++; $display("FAIL stream_timeout: got %0d words expected 3", instr_log.size());
        end else begin
            checks++; if (instr_log[0] !== 16'h1111) begin errors++; $display("FAIL stream_i0: got %h expected 1111", instr_log[0]); end
            checks++; if (instr_log[1] !== 16'h2222) begin errors++; $display("FAIL stream_i1: got %h expected 2222", instr_log[1]); end
            checks++; if (instr_log[2] !== 16'h3333) begin errors++; $display("FAIL stream_i2: got %h expected 3333", instr_log[2]); end
            checks++; if (pc4_log[0] !== 16'h0002) begin errors++; $display("FAIL stream_p0: got %h expected 0002", pc4_log[0]); end
            checks++; if (pc4_log[1] !== 16'h0004) begin errors++; $display("FAIL stream_p1: got %h expected 0004", pc4_log[1]); end
            checks++; if (pc4_log[2] !== 16'h0006) begin errors++; $display("FAIL stream_p2: got %h expected 0006", pc4_log[2]); end
            checks++; if (addr_log[0] !== 16'h0000) begin errors++; $display("FAIL stream_a0: got %h expected 0000", addr_log[0]); end
            checks++; if (addr_log[1] !== 16'h0002) begin errors++; $display("FAIL stream_a1: got %h expected 0002", addr_log[1]); end
            checks++; if (addr_log[2] !== 16'h0004) begin errors++; $display("FAIL stream_a2: got %h expected 0004", addr_log[2]); end
        end
    endtask

    task automatic test_full_backpressure();
        int n;
        do_reset();
        id_ready = 1'b0;
        repeat (12) step();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 16'h0008) begin errors++; $display("FAIL full_addr: got %h expected 0008", imem_addr); end
        checks++; if (id_instr !== 16'h1111) begin errors++; $display("FAIL full_head: got %h expected 1111", id_instr); end
        id_ready = 1'b1;
        n = 0;
        while ((instr_log.size() < 4 || addr_log.size() < 5) && n < 40) begin step(); n++; end
        checks++;
        if (instr_log.size() < 4 || addr_log.size() < 5) begin
            errors++; $display("FAIL drain_timeout: got %0d words expected 4", instr_log.size());
        end else begin
            checks++; if (instr_log[0] !== 16'h1111 || pc4_log[0] !== 16'h0002) begin errors++; $display("FAIL drain_0: got %h/%h expected 1111/0002", instr_log[0], pc4_log[0]); end
            checks++; if (instr_log[1] !== 16'h2222 || pc4_log[1] !== 16'h0004) begin errors++; $display("FAIL drain_1: got %h/%h expected 2222/0004", instr_log[1], pc4_log[1]); end
            checks++; if (instr_log[2] !== 16'h3333 || pc4_log[2] !== 16'h0006) begin errors++; $display("FAIL drain_2: got %h/%h expected 3333/0006", instr_log[2], pc4_log[2]); end
            checks++; if (instr_log[3] !== 16'h4444 || pc4_log[3] !== 16'h0008) begin errors++; $display("FAIL drain_3: got %h/%h expected 4444/0008", instr_log[3], pc4_log[3]); end
            checks++; if (addr_log[4] !== 16'h0008) begin errors++; $display("FAIL resume_addr: got %h expected 0008", addr_log[4]); end
        end
    endtask

    task automatic test_redirect_outstanding();
        int n;
        do_reset();
        n = 0;
        while (addr_log.size() < 3 && n < 40) begin
            hold_resp = (addr_log.size() >= 2);
            step();
            n++;
        end
        checks++; if (addr_log.size() < 3 || addr_log[2] !== 16'h0004) begin errors++; $display("FAIL redir_setup: got %0d requests expected 3 ending at 0004", addr_log.size()); end
        redirect      = 1'b1;
        redirect_addr = 16'h0040;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_no_req: got %b expected 0", imem_req); end
        step();
        redirect = 1'b0;
        instr_log.delete();
        pc4_log.delete();
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL redir_flush: got %0d expected 0", count); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_wait: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 16'h0040) begin errors++; $display("FAIL redir_addr: got %h expected 0040", imem_addr); end
        hold_resp = 1'b0;
        step();
        step();
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL redir_drop: got %0d expected 0", count); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL redir_resume: got %b expected 1", imem_req); end
        n = 0;
        while (instr_log.size() < 1 && n < 20) begin step(); n++; end
        checks++;
        if (instr_log.size() < 1) begin
            errors++; $display("FAIL redir_timeout: got 0 words expected 1");
        end else begin
            checks++; if (pc4_log[0] !== 16'h0042) begin errors++; $display("FAIL redir_pc4: got %h expected 0042", pc4_log[0]); end
            checks++; if (instr_log[0] !== 16'h1111) begin errors++; $display("FAIL redir_instr: got %h expected 1111", instr_log[0]); end
        end
`ifdef PREFETCH_PERF_CNT_EN
        checks++; if (perf_fetched !== 16'd3) begin errors++; $display("FAIL perf_fetched: got %0d expected 3", perf_fetched); end
        checks++; if (perf_dropped !== 16'd1) begin errors++; $display("FAIL perf_dropped: got %0d expected 1", perf_dropped); end
`endif
    endtask

    task automatic test_redirect_with_rvalid();
        int n;
        do_reset();
        id_ready = 1'b0;
        n = 0;
        while (!(count == 3'd3 && imem_rvalid) && n < 40) begin step(); n++; end
        checks++; if (count !== 3'd3 || imem_rvalid !== 1'b1) begin errors++; $display("FAIL rv_setup: got count %0d rvalid %b expected 3/1", count, imem_rvalid); end
        redirect      = 1'b1;
        redirect_addr = 16'h0100;
        step();
        redirect = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rv_flush: got %0d expected 0", count); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rv_valid: got %b expected 0", id_valid); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rv_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 16'h0100) begin errors++; $display("FAIL rv_addr: got %h expected 0100", imem_addr); end
        id_ready = 1'b1;
        instr_log.delete();
        pc4_log.delete();
        n = 0;
        while (instr_log.size() < 1 && n < 20) begin step(); n++; end
        checks++;
        if (instr_log.size() < 1) begin
            errors++; $display("FAIL rv_timeout: got 0 words expected 1");
        end else begin
            checks++; if (pc4_log[0] !== 16'h0102) begin errors++; $display("FAIL rv_pc4: got %h expected 0102", pc4_log[0]); end
        end
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        id_ready = 1'b0;
        n = 0;
        while (count != 3'd2 && n < 40) begin step(); n++; end
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL ar_setup: got %0d expected 2", count); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", id_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ar_req: got %b expected 0", imem_req); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL ar_count: got %0d expected 0", count); end
        pending     = 1'b0;
        imem_rvalid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n     = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hDEAD;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL ar_first: got %b/%h expected 1/0000", imem_req, imem_addr); end
        step();
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL ar_stale: got %0d expected 0", count); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full_backpressure();
        test_redirect_outstanding();
        test_redirect_with_rvalid();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
